inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Sequential instruction fetcher directly upstream of the issue stage. Holds
//  the fetch PC, issues one-word reads to the memory controller, and buffers
//  returned instructions with their PCs in a FIFO instruction queue. Presents
//  the queue head to issue as inst_valid/inst_to_issue/pc_to_issue. Redirects
//  and flushes on jumps from the ROB. No branch prediction: fetch is strictly
//  PC+4.
// PARAMETERS
//  IQ_DEPTH      16  instruction queue entries; power of 2, >=2
//  ICACHE_LINES  64  direct-mapped I-cache words; power of 2; used only with ICACHE_EN
//  RESET_PC      0   fetch PC after reset
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous reset, active-high
//  rdy            in   1   global ready; 0 freezes all state
//  issue_stall    in   1   downstream (ROB/RS/LSB) full; head must not be consumed
//  inst_valid     out  1   head valid and consumed this cycle by issue
//  inst_to_issue  out  32  head instruction word
//  pc_to_issue    out  32  head instruction PC
//  jump_enable    in   1   redirect/flush request from ROB commit
//  jump_pc        in   32  redirect target
//  mem_req_valid  out  1   read request to memory controller
//  mem_req_addr   out  32  word address (byte address, [1:0]=0)
//  mem_resp_valid in   1   1-cycle pulse: read data returned
//  mem_resp_data  in   32  returned instruction word
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC; queue empty (head=tail=count=0);
//   state=IDLE; mem_req_valid=0; mem_req_addr=0; inst_valid=0. Outputs
//   inst_to_issue and pc_to_issue are 0 while empty.
//  rdy=0: no register updates; inst_valid forced 0. mem_req_valid and
//   mem_req_addr hold. mem_resp_valid is sampled only when rdy=1; the memory
//   controller shares rdy.
//  Issue side (combinational): inst_valid = rdy & (count!=0) & !issue_stall
//   & !jump_enable. inst_valid=1 means pop at the clock edge; issue must accept.
//  FSM states:
//   IDLE:    when count<IQ_DEPTH and !jump_enable: mem_req_valid<=1,
//            mem_req_addr<=fetch_pc, goto WAIT. Otherwise stay.
//   WAIT:    request held stable. On mem_resp_valid: push {data,fetch_pc},
//            fetch_pc<=fetch_pc+4 (mod 2^32), mem_req_valid<=0, goto IDLE.
//   DISCARD: flushed request still in flight. On mem_resp_valid: drop data,
//            mem_req_valid<=0, goto IDLE.
//  Single outstanding request; best-case throughput 1 inst / (2+mem latency).
//  Full: no request is started when count==IQ_DEPTH. A push never occurs on a
//   full queue, because count is checked at request start and only pops occur
//   meanwhile. Push+pop in the same cycle leaves count unchanged.
//  Pointers wrap modulo IQ_DEPTH; count is $clog2(IQ_DEPTH)+1 bits.
//  jump_enable (any state, highest priority): queue cleared, no pop,
//   fetch_pc<=jump_pc.
//   IDLE or WAIT-without-resp: WAIT goes to DISCARD, IDLE stays IDLE.
//   WAIT with mem_resp_valid in the same cycle: response dropped, goto IDLE.
//   DISCARD with mem_resp_valid: goto IDLE.
//   A second jump while in DISCARD only updates fetch_pc.
// CONFIGURATION
//  ICACHE_EN defined: direct-mapped I-cache of ICACHE_LINES words.
//   index = pc[$clog2(ICACHE_LINES)+1:2]; tag = remaining upper PC bits.
//   IDLE hit with room and no jump: push cached word in the same cycle, no
//    memory request, fetch_pc+=4 (1 inst/cycle). Miss: normal request.
//   Fill on every accepted (non-discarded) response.
//   Valid bits are cleared by rst only; jumps do not invalidate.
//  ICACHE_EN undefined: no cache storage; every fetch goes to memory.
// TESTING
//  1 reset, memory returns 0x00000013 after 2 cycles, no stall -> first
//    inst_valid with pc_to_issue=0, then pc 4, 8 in order.
//  2 issue_stall=1 for 100 cycles -> exactly 16 fetches, then
//    mem_req_valid stays 0; release -> pops pc 0..0x3C in order.
//  3 jump_enable, jump_pc=0x100, while WAIT -> queue empty next cycle; stale
//    resp dropped; next request addr 0x100.
//  4 jump coincident with mem_resp_valid -> data not pushed; next addr=jump_pc.
//  5 rdy=0 for 5 cycles mid-WAIT -> addr and outputs frozen, inst_valid=0;
//    resumes identically.
//  6 ICACHE_EN: loop 0x0..0xC then jump to 0x0 -> second pass no mem requests,
//    1 inst/cycle.

Source files
------------

// File: rtl/inst_fetch.sv
// Sequential PC+4 instruction fetcher feeding the issue stage through a FIFO instruction queue.
// Define ICACHE_EN to add a direct-mapped instruction cache in front of the memory controller.
module inst_fetch #(
  parameter int unsigned IQ_DEPTH     = 16,
  parameter int unsigned ICACHE_LINES = 64,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        issue_stall,
  output logic        inst_valid,
  output logic [31:0] inst_to_issue,
  output logic [31:0] pc_to_issue,
  input  logic        jump_enable,
  input  logic [31:0] jump_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);
  localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      iq_inst [IQ_DEPTH];
  logic [31:0]      iq_pc   [IQ_DEPTH];

  logic        has_room;
  logic        not_empty;
  logic        pop;
  logic        resp_push;
  logic        hit_push;
  logic        push;
  logic [31:0] push_inst;

  assign not_empty = (count != '0);
  assign has_room  = (count < CNT_W'(IQ_DEPTH));
  assign pop       = rdy && not_empty && !issue_stall && !jump_enable;
  assign resp_push = rdy && !jump_enable && (state == S_WAIT) && mem_resp_valid;
  assign push      = resp_push || hit_push;

  // Queue head is presented directly; zeroed while the queue is empty.
  assign inst_valid    = pop;
  assign inst_to_issue = not_empty ? iq_inst[head] : 32'h0;
  assign pc_to_issue   = not_empty ? iq_pc[head]   : 32'h0;

`ifdef ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [31:0]             ic_data [ICACHE_LINES];
  logic [TAG_W-1:0]        ic_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] ic_valid;
  logic [IDX_W-1:0]        ic_idx;
  logic                    ic_hit;

  // fetch_pc is stable during WAIT, so one index serves both lookup and fill.
  assign ic_idx    = fetch_pc[IDX_W+1:2];
  assign ic_hit    = ic_valid[ic_idx] && (ic_tag[ic_idx] == fetch_pc[31:IDX_W+2]);
  assign hit_push  = rdy && !jump_enable && (state == S_IDLE) && has_room && ic_hit;
  assign push_inst = hit_push ? ic_data[ic_idx] : mem_resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_valid <= '0;
    end else if (resp_push) begin
      ic_valid[ic_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_push) begin
      ic_data[ic_idx] <= mem_resp_data;
      ic_tag[ic_idx]  <= fetch_pc[31:IDX_W+2];
    end
  end
`else
  logic unused_lines;

  assign hit_push     = 1'b0;
  assign push_inst    = mem_resp_data;
  assign unused_lines = ICACHE_LINES[0];
`endif

  // Queue storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      iq_inst[tail] <= push_inst;
      iq_pc[tail]   <= fetch_pc;
    end
  end

  // Fetch control: jumps flush the queue and override every other action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      fetch_pc      <= RESET_PC;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'h0;
    end else if (rdy) begin
      if (jump_enable) begin
        fetch_pc <= jump_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        case (state)
          S_WAIT, S_DISCARD: begin
            if (mem_resp_valid) begin
              state         <= S_IDLE;
              mem_req_valid <= 1'b0;
            end else begin
              state <= S_DISCARD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
        case (state)
          S_IDLE: begin
            if (hit_push) begin
              fetch_pc <= fetch_pc + 32'd4;
            end else if (has_room) begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= fetch_pc;
              state         <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_resp_valid) begin
              fetch_pc      <= fetch_pc + 32'd4;
              mem_req_valid <= 1'b0;
              state         <= S_IDLE;
            end
          end
          S_DISCARD: begin
            if (mem_resp_valid) begin
              mem_req_valid <= 1'b0;
              state         <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic checked against a transaction-level fetch model.
// Define ICACHE_EN for both files to exercise the cached build.
module tb_inst_fetch;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LINES = 64;

  logic        clk = 1'b0;
  logic        rst, rdy, issue_stall, inst_valid, jump_enable;
  logic        mem_req_valid, mem_resp_valid;
  logic [31:0] inst_to_issue, pc_to_issue, jump_pc, mem_req_addr, mem_resp_data;

  inst_fetch #(.IQ_DEPTH(DEPTH), .ICACHE_LINES(LINES), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .issue_stall(issue_stall),
    .inst_valid(inst_valid), .inst_to_issue(inst_to_issue), .pc_to_issue(pc_to_issue),
    .jump_enable(jump_enable), .jump_pc(jump_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] inst; logic [31:0] pc; } entry_t;

  int checks = 0;
  int errors = 0;

  // Reference model: queue contents, fetch PC, one outstanding request (possibly stale).
  entry_t      q[$];
  logic [31:0] m_fpc, m_addr;
  bit          m_req, m_stale;
  bit          c_valid[LINES];
  logic [31:0] c_pc[LINES];
  logic [31:0] c_data[LINES];

  // Memory controller model.
  bit          mem_busy, const_mode;
  int          mem_cnt, lat, mem_accepts, acc_low;
  logic [31:0] mem_addr;

  logic [31:0] popped[$];
  int          pop_cyc[$];
  int          cyc;
  bit          found;
  logic [31:0] held_addr;
  int          base;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return const_mode ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; jump_enable = 1'b0; issue_stall = 1'b0; rdy = 1'b1; mem_resp_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst_to_issue, 32'h0);
    chk("rst_pc", pc_to_issue, 32'h0);
    q.delete();
    m_fpc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_stale = 1'b0;
    for (int i = 0; i < int'(LINES); i++) c_valid[i] = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive_mem();
    mem_resp_valid = 1'b0;
    mem_resp_data  = $urandom;
    if (rdy && mem_busy && mem_cnt == 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(mem_addr);
    end
  endtask

  task automatic clock_step();
    int          sz, idx;
    bit          exp_v, hit, req_seen;
    logic [31:0] req_a;
    @(negedge clk);
    cyc++;
    sz    = q.size();
    exp_v = rdy && (sz != 0) && !issue_stall && !jump_enable;
    chk("inst_valid", 32'(inst_valid), 32'(exp_v));
    chk("inst_to_issue", inst_to_issue, (sz != 0) ? q[0].inst : 32'h0);
    chk("pc_to_issue", pc_to_issue, (sz != 0) ? q[0].pc : 32'h0);
    chk("mem_req_valid", 32'(mem_req_valid), 32'(m_req));
    chk("mem_req_addr", mem_req_addr, m_addr);
    if (inst_valid) begin
      popped.push_back(pc_to_issue);
      pop_cyc.push_back(cyc);
    end
    req_seen = mem_req_valid;
    req_a    = mem_req_addr;
    if (rdy) begin
      if (jump_enable) begin
        q.delete();
        m_fpc = jump_pc;
        if (m_req) begin
          if (mem_resp_valid) begin m_req = 1'b0; m_stale = 1'b0; end
          else m_stale = 1'b1;
        end
      end else begin
        if (exp_v) void'(q.pop_front());
        idx = int'((m_fpc >> 2) % LINES);
        if (m_req) begin
          if (mem_resp_valid) begin
            if (!m_stale) begin
              q.push_back({mem_resp_data, m_fpc});
              c_valid[idx] = 1'b1; c_pc[idx] = m_fpc; c_data[idx] = mem_resp_data;
              m_fpc = m_fpc + 32'd4;
            end
            m_req = 1'b0; m_stale = 1'b0;
          end
        end else if (sz < int'(DEPTH)) begin
          hit = 1'b0;
`ifdef ICACHE_EN
          hit = c_valid[idx] && (c_pc[idx] == m_fpc);
`endif
          if (hit) begin
            q.push_back({c_data[idx], m_fpc});
            m_fpc = m_fpc + 32'd4;
          end else begin
            m_req = 1'b1; m_addr = m_fpc;
          end
        end
      end
    end
    @(posedge clk);
    if (rdy) begin
      if (mem_resp_valid) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      else if (req_seen) begin
        mem_busy = 1'b1; mem_cnt = lat; mem_addr = req_a; mem_accepts++;
        if (req_a < 32'd16) acc_low++;
      end
    end
    #1;
  endtask

  task automatic step();
    drive_mem();
    clock_step();
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; issue_stall = 1'b0; jump_enable = 1'b0; jump_pc = 32'h0;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0; lat = 2; const_mode = 1'b1;
    cyc = 0; mem_accepts = 0; acc_low = 0;
    #2;
    do_reset();

    // Fixed-latency memory returning a constant word: pops in PC order.
    popped.delete();
    for (int i = 0; i < 30; i++) step();
    chk("t1_npop", 32'(popped.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      chk("t1_pc", (popped.size() > i) ? popped[i] : 32'hFFFF_FFFF, 32'(i * 4));

    // Stalled issue: exactly DEPTH fetches, then the queue drains in order.
    do_reset();
    const_mode = 1'b0; lat = 0; issue_stall = 1'b1; mem_accepts = 0;
    for (int i = 0; i < 100; i++) step();
    chk("t2_fetches", 32'(mem_accepts), 32'd16);
    chk("t2_req_idle", 32'(mem_req_valid), 32'd0);
    issue_stall = 1'b0; popped.delete();
    for (int i = 0; i < 20; i++) step();
    for (int i = 0; i < 16; i++)
      chk("t2_drain_pc", (popped.size() > i) ? popped[i] : 32'hFFFF_FFFF, 32'(i * 4));

    // Jump while waiting: flush, stale response dropped, refetch at target.
    lat = 3; found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      drive_mem();
      if (m_req && !m_stale && !mem_resp_valid) begin
        found = 1'b1; jump_enable = 1'b1; jump_pc = 32'h100;
      end
      clock_step();
      jump_enable = 1'b0;
    end
    chk("t3_found", 32'(found), 32'd1);
    chk("t3_empty_pc", pc_to_issue, 32'h0);
    chk("t3_empty_valid", 32'(inst_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (mem_req_valid && !m_stale) found = 1'b1;
      else step();
    end
    chk("t3_next_addr", mem_req_addr, 32'h100);

    // Jump coincident with a response: data not pushed, next request at target.
    lat = 1; found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      drive_mem();
      if (mem_resp_valid) begin found = 1'b1; jump_enable = 1'b1; jump_pc = 32'h200; end
      clock_step();
      jump_enable = 1'b0;
    end
    chk("t4_found", 32'(found), 32'd1);
    chk("t4_empty_pc", pc_to_issue, 32'h0);
    step();
    chk("t4_next_valid", 32'(mem_req_valid), 32'd1);
    chk("t4_next_addr", mem_req_addr, 32'h200);

    // rdy low mid-WAIT: request and outputs frozen, no pops.
    lat = 2; step(); step();
    held_addr = mem_req_addr;
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_addr_hold", mem_req_addr, held_addr);
      chk("t5_no_pop", 32'(inst_valid), 32'd0);
    end
    rdy = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // PC wrap-around at the top of the address space.
    drive_mem(); jump_enable = 1'b1; jump_pc = 32'hFFFF_FFF8; clock_step(); jump_enable = 1'b0;
    popped.delete();
    for (int i = 0; i < 40; i++) step();
    chk("wrap_pc", (popped.size() > 2) ? popped[2] : 32'hDEAD_BEEF, 32'h0);

    // Random traffic: stalls, rdy gaps, jumps into a small aliasing address range.
    do_reset();
    const_mode = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      lat         = $urandom_range(0, 3);
      issue_stall = (i < 500) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      rdy         = ($urandom_range(0, 9) != 0);
      drive_mem();
      jump_enable = ($urandom_range(0, 39) == 0);
      jump_pc     = (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0) + (32'($urandom_range(0, 63)) << 2);
      clock_step();
    end
    rdy = 1'b1; issue_stall = 1'b0; jump_enable = 1'b0;

`ifdef ICACHE_EN
    // Loop 0x0..0xC then jump back: second pass served from cache at one per cycle.
    do_reset();
    lat = 1; popped.delete();
    for (int i = 0; i < 100 && popped.size() < 4; i++) step();
    chk("t6_first_pass", 32'(popped.size() >= 4), 32'd1);
    drive_mem(); jump_enable = 1'b1; jump_pc = 32'h0; clock_step(); jump_enable = 1'b0;
    popped.delete(); pop_cyc.delete(); base = acc_low;
    for (int i = 0; i < 40 && popped.size() < 4; i++) step();
    chk("t6_npop", 32'(popped.size()), 32'd4);
    chk("t6_low_reqs", 32'(acc_low - base), 32'd0);
    chk("t6_rate", (pop_cyc.size() >= 4) ? 32'(pop_cyc[3] - pop_cyc[0]) : 32'hFFFF_FFFF, 32'd3);
    for (int i = 0; i < 4; i++)
      chk("t6_pc", (popped.size() > i) ? popped[i] : 32'hFFFF_FFFF, 32'(i * 4));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
